// File: rtl/rx_bit_timer.sv
// Bit/byte timing generator for the USB receive path: mid-bit sample strobe,
// end-of-bit/byte strobes, edge resync, stuffed-bit skip, saturating byte count.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_PHASE  = 3,
  parameter int BITS_PER_BYTE = 8,
  parameter int BYTE_W        = 8,
  localparam int PD_W = $clog2(CLKS_PER_BIT),
  localparam int BC_W = $clog2(BITS_PER_BYTE)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              timer_en,
  input  logic              timer_clr,
  input  logic              restart,
  input  logic              resync_en,
  input  logic              edge_det,
  input  logic              stuff_skip,
  output logic              shift_strobe,
  output logic              bit_done,
  output logic              byte_done,
  output logic [PD_W-1:0]   pd_count,
  output logic [BC_W-1:0]   bit_count,
  output logic [BYTE_W-1:0] byte_count
);

  localparam logic [PD_W-1:0] PD_LAST   = PD_W'(CLKS_PER_BIT - 1);
  localparam logic [PD_W-1:0] PD_SAMPLE = PD_W'(SAMPLE_PHASE);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BITS_PER_BYTE - 1);

  logic            active;
  logic            resync_hit;
  logic            early_edge;
  logic            pd_last;
  logic [PD_W-1:0] pd_next;

  assign active  = timer_en & ~timer_clr & ~restart;
  assign pd_last = (pd_count == PD_LAST);

  // Edges at the bit boundary or on the sample point are ignored so a bit is
  // never sampled twice.
  assign resync_hit = resync_en & edge_det & (pd_count != '0) & (pd_count != PD_SAMPLE);
  assign early_edge = resync_hit & (pd_count > PD_SAMPLE);

  assign shift_strobe = active & (pd_count == PD_SAMPLE);
  assign bit_done     = active & (pd_last | early_edge);
  assign byte_done    = bit_done & ~stuff_skip & (bit_count == BC_LAST);

  // The edge cycle counts as cycle 0 of the new bit, hence the load of 1.
  always_comb begin
    pd_next = pd_count + PD_W'(1);
    if (resync_hit)
      pd_next = PD_W'(1);
    else if (pd_last)
      pd_next = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pd_count   <= '0;
      bit_count  <= '0;
      byte_count <= '0;
    end else if (timer_clr) begin
      pd_count   <= '0;
      bit_count  <= '0;
      byte_count <= '0;
    end else if (restart) begin
      pd_count  <= '0;
      bit_count <= '0;
    end else if (timer_en) begin
      pd_count <= pd_next;
      if (bit_done && !stuff_skip)
        bit_count <= (bit_count == BC_LAST) ? '0 : bit_count + BC_W'(1);
      if (byte_done && (byte_count != '1))
        byte_count <= byte_count + BYTE_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: per-cycle vector table plus hand-written
// multi-cycle sequences for free-run, stuffing, saturation, hold and reset.
module tb_rx_bit_timer;

  logic       clk;
  logic       n_rst;
  logic       timer_en, timer_clr, restart, resync_en, edge_det, stuff_skip;
  logic       shift_strobe, bit_done, byte_done;
  logic [2:0] pd_count;
  logic [2:0] bit_count;
  logic [7:0] byte_count;

  int tests = 0;
  int fails = 0;

  rx_bit_timer #(
    .CLKS_PER_BIT(8), .SAMPLE_PHASE(3), .BITS_PER_BYTE(8), .BYTE_W(8)
  ) dut (
    .clk(clk), .n_rst(n_rst), .timer_en(timer_en), .timer_clr(timer_clr),
    .restart(restart), .resync_en(resync_en), .edge_det(edge_det),
    .stuff_skip(stuff_skip), .shift_strobe(shift_strobe), .bit_done(bit_done),
    .byte_done(byte_done), .pd_count(pd_count), .bit_count(bit_count),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en, clr, rs, rse, ed, st;
    logic es, ebd, eby;
    int   epd, ebc;
  } vec_t;

  vec_t tbl[35];

  function automatic vec_t v(input logic en, clr, rs, rse, ed, st,
                             input logic es, ebd, eby, input int epd, ebc);
    vec_t r;
    r.en = en; r.clr = clr; r.rs = rs; r.rse = rse; r.ed = ed; r.st = st;
    r.es = es; r.ebd = ebd; r.eby = eby; r.epd = epd; r.ebc = ebc;
    return r;
  endfunction

  // Packed view {shift, bit_done, byte_done, pd[2:0], bit_count[2:0]}
  function automatic int pk(input logic s, bd, by, input int pd, bc);
    return (int'(s) << 8) | (int'(bd) << 7) | (int'(by) << 6) | ((pd & 7) << 3) | (bc & 7);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, clr, rs, rse, ed, st);
    timer_en = en; timer_clr = clr; restart = rs;
    resync_en = rse; edge_det = ed; stuff_skip = st;
  endtask

  task automatic do_reset;
    n_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  function automatic int act_pk();
    return pk(shift_strobe, bit_done, byte_done, int'(pd_count), int'(bit_count));
  endfunction

  int exp_bc;
  int pulses;

  initial begin
    //            en clr rs rse ed st   s bd by pd bc
    tbl[0]  = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    tbl[2]  = v(1, 0, 0, 1, 1, 0,   0, 0, 0, 2, 0);  // late edge
    tbl[3]  = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    tbl[4]  = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0);
    tbl[5]  = v(1, 0, 0, 1, 1, 0,   1, 0, 0, 3, 0);  // edge on sample point ignored
    tbl[6]  = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 4, 0);
    tbl[7]  = v(1, 0, 0, 1, 1, 0,   0, 1, 0, 5, 0);  // early edge forces bit_done
    tbl[8]  = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1);
    tbl[9]  = v(1, 0, 0, 0, 1, 0,   0, 0, 0, 2, 1);  // resync disabled
    tbl[10] = v(1, 0, 0, 0, 0, 0,   1, 0, 0, 3, 1);
    tbl[11] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 4, 1);
    tbl[12] = v(1, 1, 0, 1, 1, 0,   0, 0, 0, 5, 1);  // clr beats edge
    tbl[13] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[14] = v(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    tbl[15] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    tbl[16] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0);
    tbl[17] = v(1, 0, 0, 0, 0, 0,   1, 0, 0, 3, 0);
    tbl[18] = v(1, 0, 1, 0, 0, 0,   0, 0, 0, 4, 0);  // restart
    tbl[19] = v(1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0);  // edge at boundary ignored
    tbl[20] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    tbl[21] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0);
    tbl[22] = v(1, 0, 0, 0, 0, 0,   1, 0, 0, 3, 0);
    tbl[23] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 4, 0);
    tbl[24] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 5, 0);
    tbl[25] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 6, 0);
    tbl[26] = v(1, 0, 0, 1, 1, 0,   0, 1, 0, 7, 0);  // edge at last cycle
    tbl[27] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1);
    tbl[28] = v(1, 0, 0, 0, 0, 1,   0, 0, 0, 2, 1);  // stuff outside bit_done
    tbl[29] = v(1, 0, 0, 0, 0, 0,   1, 0, 0, 3, 1);
    tbl[30] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 4, 1);
    tbl[31] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 5, 1);
    tbl[32] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 6, 1);
    tbl[33] = v(1, 0, 0, 0, 0, 1,   0, 1, 0, 7, 1);  // stuffed bit
    tbl[34] = v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);

    do_reset();
    chk("reset_byte_count", int'(byte_count), 0);
    for (int i = 0; i < 35; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].rs, tbl[i].rse, tbl[i].ed, tbl[i].st);
      #1;
      chk($sformatf("vec%0d", i), act_pk(),
          pk(tbl[i].es, tbl[i].ebd, tbl[i].eby, tbl[i].epd, tbl[i].ebc));
      @(negedge clk);
    end

    // Free-run for one byte
    do_reset();
    for (int c = 0; c < 64; c++) begin
      drive(1, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("freerun_c%0d", c), act_pk(),
          pk(c % 8 == 3, c % 8 == 7, c == 63, c % 8, (c / 8) % 8));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("freerun_byte_count", int'(byte_count), 1);

    // Stuffed bit at the 4th bit_done delays byte_done by one bit period
    do_reset();
    for (int c = 0; c < 80; c++) begin
      drive(1, 0, 0, 0, 0, c == 31);
      #1;
      if (c < 32)      exp_bc = c / 8;
      else if (c < 40) exp_bc = 3;
      else             exp_bc = (c / 8 - 1) % 8;
      chk($sformatf("stuff_c%0d", c), act_pk(),
          pk(c % 8 == 3, c % 8 == 7, c == 71, c % 8, exp_bc));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("stuff_byte_count", int'(byte_count), 1);

    // Saturation
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (255 * 64) @(negedge clk);
    #1;
    chk("sat_at_255", int'(byte_count), 255);
    pulses = 0;
    for (int c = 0; c < 5 * 64; c++) begin
      #1;
      if (byte_done) pulses++;
      @(negedge clk);
    end
    #1;
    chk("sat_held", int'(byte_count), 255);
    chk("sat_byte_done_pulses", pulses, 5);

    // timer_en hold at pd_count=4
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("hold_c%0d", c), act_pk(), pk(0, 0, 0, 4, 0));
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("resume_c%0d", c), act_pk(), pk(0, c == 3, 0, 4 + c, 0));
      @(negedge clk);
    end

    // restart keeps byte_count
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (128 + 20) @(negedge clk);
    drive(1, 0, 1, 0, 0, 0);
    #1;
    chk("restart_cycle", act_pk(), pk(0, 0, 0, 4, 2));
    chk("restart_bytes_pre", int'(byte_count), 2);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("restart_after", act_pk(), pk(0, 0, 0, 0, 0));
    chk("restart_bytes_post", int'(byte_count), 2);

    // Async reset mid-byte, away from any clock edge
    repeat (19) @(negedge clk);
    #1;
    chk("pre_async_state", act_pk(), pk(0, 0, 0, 3, 2) | 256);
    #1;
    n_rst = 1'b0;
    #1;
    chk("async_rst_strobes", act_pk(), pk(0, 0, 0, 0, 0));
    chk("async_rst_bytes", int'(byte_count), 0);
    @(negedge clk);
    n_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
